// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between an I-cache (line
// reads only) and a D-cache (line reads and writebacks).
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   i_read, i_addr             I-cache read request, held until i_resp
//   i_rdata, i_resp            line data (pmem pass-through), completion pulse
//   d_read, d_write, d_addr,   D-cache request, held until d_resp; a request
//   d_wdata                    with both d_read and d_write is a write
//   d_rdata, d_resp            line data (pmem pass-through), completion pulse
//   pmem_read, pmem_write,     physical memory request, driven from the
//   pmem_addr, pmem_wdata      latched request while serving
//   pmem_rdata, pmem_resp      physical memory data and completion
//
// A grant taken in IDLE is latched, so requester inputs may change while it
// is being served. DONE is a one-cycle gap after every completion so that a
// requester dropping its request on resp is never granted a second time.
module mem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1: D-cache won the most recent grant
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              d_req;
    logic              grant_d;

    // Read data is shared by both caches; only the resp pulses qualify it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // State and latched request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
        end
    end

    // Arbitration, next state and memory-side outputs
    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        d_req      = d_read | d_write;
        grant_d    = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie, D wins unless it was the last one granted.
                grant_d = d_req & (~i_read | ~last_d_q);
                if (grant_d) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    write_d  = d_write;
                end else if (i_read) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = i_addr;
                    write_d  = 1'b0;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                pmem_addr = addr_q;
                i_resp    = pmem_resp;
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            SERVE_D: begin
                pmem_read  = ~write_q;
                pmem_write = write_q;
                pmem_addr  = addr_q;
                pmem_wdata = wdata_q;
                d_resp     = pmem_resp;
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a transaction model.
module tb_mem_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, pmem_resp;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, pmem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // Model: who currently owns the memory (0 none, 1 I, 2 D), whether we are
    // in the mandatory gap after a completion, and the request captured at grant.
    int            own;
    bit            gap;
    bit            last_was_d;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            m_wr;
    bit            m_done_i, m_done_d;

    // Random memory latency bookkeeping
    int lat;
    bit lat_armed;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_compare();
        bit exp_rd, exp_wr, exp_ir, exp_dr;
        exp_rd = (own == 1) || (own == 2 && !m_wr);
        exp_wr = (own == 2) && m_wr;
        exp_ir = (own == 1) && pmem_resp;
        exp_dr = (own == 2) && pmem_resp;
        chk("pmem_read",  LW'(pmem_read),  LW'(exp_rd));
        chk("pmem_write", LW'(pmem_write), LW'(exp_wr));
        chk("i_resp",     LW'(i_resp),     LW'(exp_ir));
        chk("d_resp",     LW'(d_resp),     LW'(exp_dr));
        chk("i_rdata",    i_rdata,         pmem_rdata);
        chk("d_rdata",    d_rdata,         pmem_rdata);
        if (own != 0) chk("pmem_addr", LW'(pmem_addr), LW'(m_addr));
        if (own == 2) chk("pmem_wdata", pmem_wdata, m_wdata);
    endtask

    task automatic model_edge();
        bit want_i, want_d, pick_d;
        m_done_i = 1'b0;
        m_done_d = 1'b0;
        want_i   = i_read;
        want_d   = d_read | d_write;
        if (!rst) begin
            own = 0; gap = 1'b0; last_was_d = 1'b0;
            m_addr = '0; m_wdata = '0; m_wr = 1'b0;
        end else if (own == 0 && !gap) begin
            pick_d = (want_i && want_d) ? !last_was_d : want_d;
            if (want_i || want_d) begin
                last_was_d = pick_d;
                if (pick_d) begin
                    own = 2; m_addr = d_addr; m_wdata = d_wdata; m_wr = d_write;
                end else begin
                    own = 1; m_addr = i_addr; m_wr = 1'b0;
                end
            end
        end else if (own != 0) begin
            if (pmem_resp) begin
                if (own == 1) m_done_i = 1'b1;
                else          m_done_d = 1'b1;
                own = 0;
                gap = 1'b1;
            end
        end else begin
            gap = 1'b0;
        end
    endtask

    // Outputs are checked mid-cycle; inputs change 1 time unit after the edge.
    task automatic settle();
        @(negedge clk);
        if (check_en) model_compare();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        settle();
        edge_step();
        rst = 1'b1;
    endtask

    task automatic rand_drive();
        int op;
        rst = ($urandom_range(0, 79) != 0);
        // I-cache requester
        if (i_read && m_done_i) i_read = ($urandom_range(0, 3) == 0);
        else if (i_read) begin
            if ($urandom_range(0, 3) == 0) i_addr = $urandom & ~32'h1F;
        end else if ($urandom_range(0, 2) == 0) begin
            i_read = 1'b1;
            i_addr = $urandom & ~32'h1F;
        end
        // D-cache requester
        if ((d_read || d_write) && m_done_d) begin
            d_read = 1'b0; d_write = 1'b0;
        end else if (d_read || d_write) begin
            if ($urandom_range(0, 3) == 0) begin
                d_addr  = $urandom & ~32'h1F;
                d_wdata = rnd_line();
            end
        end else if ($urandom_range(0, 2) == 0) begin
            op      = $urandom_range(0, 2);
            d_read  = (op != 1);
            d_write = (op != 0);
            d_addr  = $urandom & ~32'h1F;
            d_wdata = rnd_line();
        end
        // Physical memory: random latency when busy, stray resp when not
        if (own != 0) begin
            if (!lat_armed) begin
                lat = $urandom_range(0, 3);
                lat_armed = 1'b1;
            end
            pmem_resp = (lat == 0);
            if (lat > 0) lat--;
        end else begin
            lat_armed = 1'b0;
            pmem_resp = ($urandom_range(0, 5) == 0);
        end
        pmem_rdata = rnd_line();
    endtask

    initial begin
        logic [LW-1:0] pat_p;
        logic [LW-1:0] pat_a5;
        pat_p  = {8{32'hDEAD_BEEF}};
        pat_a5 = {32{8'hA5}};
        rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = pat_p;
        own = 0; gap = 1'b0; last_was_d = 1'b0; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
        m_done_i = 1'b0; m_done_d = 1'b0; lat = 0; lat_armed = 1'b0;

        // Reset: everything quiet in IDLE
        settle();
        edge_step();
        check_en = 1'b1;
        rst = 1'b1;
        settle();
        chk("rst_pmem_read",  LW'(pmem_read),  '0);
        chk("rst_pmem_write", LW'(pmem_write), '0);
        chk("rst_pmem_addr",  LW'(pmem_addr),  '0);
        chk("rst_pmem_wdata", pmem_wdata,      '0);
        chk("rst_i_resp",     LW'(i_resp),     '0);
        chk("rst_d_resp",     LW'(d_resp),     '0);
        edge_step();

        // I-cache only, memory answers in the third serve cycle
        i_read = 1'b1; i_addr = 32'h0000_1000;
        settle();
        chk("i_only_idle_read", LW'(pmem_read), '0);
        edge_step();
        for (int k = 0; k < 3; k++) begin
            pmem_resp = (k == 2);
            settle();
            chk("i_only_read",   LW'(pmem_read), LW'(1'b1));
            chk("i_only_addr",   LW'(pmem_addr), LW'(32'h0000_1000));
            chk("i_only_resp",   LW'(i_resp),    LW'(k == 2));
            if (k == 2) chk("i_only_rdata", i_rdata, pat_p);
            edge_step();
        end
        i_read = 1'b0; pmem_resp = 1'b0;
        settle();
        chk("i_only_done_read", LW'(pmem_read), '0);
        chk("i_only_done_resp", LW'(i_resp),    '0);
        edge_step();
        settle();
        edge_step();

        // First tie after reset goes to D, then strict alternation D,I,D,I
        do_reset();
        i_read = 1'b1; i_addr = 32'h0000_5000;
        d_read = 1'b1; d_addr = 32'h0000_6000;
        for (int t = 0; t < 4; t++) begin
            pmem_resp = 1'b0;
            settle();
            chk("rr_idle_read", LW'(pmem_read | pmem_write), '0);
            edge_step();
            pmem_resp = 1'b1;
            settle();
            chk("rr_addr",   LW'(pmem_addr), (t % 2 == 0) ? LW'(32'h0000_6000) : LW'(32'h0000_5000));
            chk("rr_d_resp", LW'(d_resp),    LW'(t % 2 == 0));
            chk("rr_i_resp", LW'(i_resp),    LW'(t % 2 == 1));
            edge_step();
            pmem_resp = 1'b0;
            settle();
            chk("rr_done_resp", LW'(i_resp | d_resp), '0);
            edge_step();
        end
        i_read = 1'b0; d_read = 1'b0;
        settle();
        edge_step();

        // D writeback with address/data changing mid-serve
        d_write = 1'b1; d_addr = 32'h0000_2040; d_wdata = pat_a5;
        settle();
        edge_step();
        d_addr = 32'h0000_3000; d_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            pmem_resp = (k == 1);
            settle();
            chk("wb_write", LW'(pmem_write), LW'(1'b1));
            chk("wb_read",  LW'(pmem_read),  '0);
            chk("wb_addr",  LW'(pmem_addr),  LW'(32'h0000_2040));
            chk("wb_wdata", pmem_wdata,      pat_a5);
            chk("wb_resp",  LW'(d_resp),     LW'(k == 1));
            edge_step();
        end
        d_write = 1'b0; pmem_resp = 1'b0;
        settle();
        chk("wb_done_resp", LW'(d_resp), '0);
        edge_step();
        settle();
        edge_step();

        // Reset while serving I abandons the transaction
        i_read = 1'b1; i_addr = 32'h0000_4000;
        settle();
        edge_step();
        settle();
        chk("rst_mid_read", LW'(pmem_read), LW'(1'b1));
        rst = 1'b0;
        edge_step();
        rst = 1'b1; i_read = 1'b0;
        settle();
        chk("rst_mid_after_read", LW'(pmem_read | pmem_write), '0);
        chk("rst_mid_after_resp", LW'(i_resp), '0);
        pmem_resp = 1'b1;
        edge_step();

        // Stray memory response in IDLE
        settle();
        chk("stray_i_resp", LW'(i_resp), '0);
        chk("stray_d_resp", LW'(d_resp), '0);
        edge_step();
        pmem_resp = 1'b0;
        settle();
        chk("stray_after_strobe", LW'(pmem_read | pmem_write), '0);
        edge_step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rand_drive();
            settle();
            edge_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cache line width in bits.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled at rising edge of clk.
REQ-005 i_read  input  1  I-cache line read request; held until i_resp.
REQ-006 i_addr  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  line data returned to I-cache.
REQ-008 i_resp  output  1  I-cache request complete, one-cycle pulse.
REQ-009 d_read  input  1  D-cache line read request; held until d_resp.
REQ-010 d_write  input  1  D-cache line writeback request; held until d_resp.
REQ-011 d_addr  input  ADDR_W  D-cache line address.
REQ-012 d_wdata  input  LINE_W  D-cache writeback data.
REQ-013 d_rdata  output  LINE_W  line data returned to D-cache.
REQ-014 d_resp  output  1  D-cache request complete, one-cycle pulse.
REQ-015 pmem_read  output  1  physical memory read strobe.
REQ-016 pmem_write  output  1  physical memory write strobe.
REQ-017 pmem_addr  output  ADDR_W  physical memory address.
REQ-018 pmem_wdata  output  LINE_W  physical memory write data.
REQ-019 pmem_rdata  input  LINE_W  physical memory read data, valid with pmem_resp.
REQ-020 pmem_resp  input  1  physical memory transaction complete.

Function
REQ-021 The block SHALL have exactly four states: IDLE, SERVE_I, SERVE_D, DONE.
REQ-022 In IDLE with only the I request pending (i_read=1), the block SHALL latch i_addr and go to SERVE_I on the next edge.
REQ-023 In IDLE with only a D request pending (d_read|d_write=1), the block SHALL latch d_addr, d_wdata and the op (write if d_write) and go to SERVE_D.
REQ-024 In IDLE with both pending, the block SHALL grant the requester not granted last (round-robin); the last_grant bit SHALL update on every grant.
REQ-025 When d_read and d_write are both 1, the block SHALL treat the request as a write.
REQ-026 In SERVE_I, pmem_read SHALL be 1, pmem_write 0, pmem_addr the latched I address.
REQ-027 In SERVE_D, pmem_read/pmem_write SHALL reflect the latched op, pmem_addr the latched D address, pmem_wdata the latched D data.
REQ-028 In IDLE and DONE, pmem_read and pmem_write SHALL be 0.
REQ-029 i_resp SHALL equal pmem_resp while in SERVE_I, else 0; d_resp SHALL equal pmem_resp while in SERVE_D, else 0 (combinational, zero added latency).
REQ-030 i_rdata and d_rdata SHALL both pass pmem_rdata through unmodified at all times.
REQ-031 On pmem_resp in SERVE_I or SERVE_D, the next state SHALL be DONE.
REQ-032 DONE SHALL last exactly one cycle, grant nothing, and return to IDLE, so a requester dropping its request after resp is never re-granted.
REQ-033 pmem_resp in IDLE or DONE SHALL be ignored; no resp output is asserted.
REQ-034 Request input changes during SERVE_* SHALL not affect pmem_addr/pmem_wdata/op (latched values hold).
REQ-035 Grant-to-pmem latency SHALL be one cycle: request seen in IDLE at edge N drives pmem strobes from edge N.
REQ-036 Minimum back-to-back turnaround SHALL be: resp cycle, DONE, IDLE, next SERVE.

Reset
REQ-037 On a rising edge with rst=0, state SHALL go to IDLE, last_grant to I (so D wins the first tie), and latched addr/wdata/op to 0.
REQ-038 Reset mid-transaction SHALL abandon it; pmem_read/pmem_write SHALL be 0 from the cycle after the reset edge, and no resp SHALL be generated for it.
REQ-039 All outputs other than rdata pass-throughs SHALL be 0 while state is IDLE after reset.

Verification
REQ-040 I only: i_read=1, i_addr=0x0000_1000, pmem_resp after 3 cycles -> pmem_read=1 with addr 0x1000 for 3 cycles; i_resp pulses once with i_rdata=pmem_rdata; DONE then IDLE.
REQ-041 Simultaneous first tie after reset: i_read=1, d_read=1 -> SERVE_D first; after DONE, SERVE_I; each resp exactly once.
REQ-042 Sustained contention, both held for 4 transactions -> grant order D,I,D,I.
REQ-043 D writeback: d_write=1, d_addr=0x0000_2040, d_wdata=0xA5 pattern; d_addr changed to 0x3000 mid-serve -> pmem_write=1, pmem_addr stays 0x2040, pmem_wdata pattern held, d_resp once.
REQ-044 Reset in SERVE_I before pmem_resp -> next cycle IDLE, strobes 0, no i_resp; later pmem_resp ignored.
REQ-045 Stray pmem_resp=1 in IDLE -> i_resp=d_resp=0, state unchanged.
